// File: rtl/ledr_shift_pkg.sv
// Shared constants and FSM state encodings for the LEDR serial shift-out block.
package ledr_shift_pkg;

    localparam int unsigned LEDR_W       = 8;
    localparam int unsigned LEDR_CLK_DIV = 4;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_SHIFT_LO = 3'd2;
    localparam logic [2:0] ST_SHIFT_HI = 3'd3;
    localparam logic [2:0] ST_LATCH    = 3'd4;

endpackage

// File: rtl/ledr_shift_tick.sv
// Phase timer: counts CLK_DIV cycles per phase, restartable, flags the last cycle of a phase.
module ledr_shift_tick
    import ledr_shift_pkg::*;
#(
    parameter int unsigned CLK_DIV = LEDR_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic phase_done
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);

    logic [CNT_W-1:0] cnt;

    // Decoded straight from the counter register, so no input reaches it combinationally.
    assign phase_done = (cnt == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt <= '0;
        end else if (phase_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ledr_shift_out.sv
// Serialises the LEDR PIO pattern into a 74HC595-style shift register whenever it changes,
// coalescing changes seen mid-transfer into a single follow-up transfer.
module ledr_shift_out
    import ledr_shift_pkg::*;
#(
    parameter int unsigned DATA_W    = LEDR_W,
    parameter int unsigned CLK_DIV   = LEDR_CLK_DIV,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] pattern,
    output logic              sr_data,
    output logic              sr_clk,
    output logic              sr_latch,
    output logic              busy
);

    localparam int unsigned BIT_W = $clog2(DATA_W + 1);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [DATA_W-1:0] last_sent;
    logic [DATA_W-1:0] last_sent_nxt;
    logic [DATA_W-1:0] capture;
    logic [DATA_W-1:0] capture_nxt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nxt;
    logic              pending;
    logic              pending_nxt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  bit_cnt_nxt;
    logic              sr_data_nxt;
    logic              sr_clk_nxt;
    logic              sr_latch_nxt;
    logic              busy_nxt;
    logic              phase_done;
    logic              restart_c;

    // Every state change starts a fresh phase.
    assign restart_c = (state_nxt != state);

    ledr_shift_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk        (clk),
        .reset      (reset),
        .restart    (restart_c),
        .phase_done (phase_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        last_sent_nxt = last_sent;
        capture_nxt   = capture;
        shreg_nxt     = shreg;
        pending_nxt   = pending;
        bit_cnt_nxt   = bit_cnt;

        // Outside a transfer compare to what the device holds; inside, to what is being shifted.
        if (state == ST_IDLE) begin
            if (pattern != last_sent) begin
                pending_nxt = 1'b1;
            end
        end else if (state != ST_LOAD) begin
            if (pattern != capture) begin
                pending_nxt = 1'b1;
            end
        end

        case (state)
            ST_IDLE: begin
                if (pending_nxt) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shreg_nxt   = pattern;
                capture_nxt = pattern;
                pending_nxt = 1'b0;
                bit_cnt_nxt = BIT_W'(DATA_W);
                state_nxt   = ST_SHIFT_LO;
            end
            ST_SHIFT_LO: begin
                if (phase_done) begin
                    state_nxt = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                if (phase_done) begin
                    shreg_nxt   = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                    bit_cnt_nxt = bit_cnt - BIT_W'(1);
                    state_nxt   = (bit_cnt == BIT_W'(1)) ? ST_LATCH : ST_SHIFT_LO;
                end
            end
            ST_LATCH: begin
                if (phase_done) begin
                    last_sent_nxt = capture;
                    state_nxt     = pending_nxt ? ST_LOAD : ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with the state they belong to.
        busy_nxt     = (state_nxt != ST_IDLE);
        sr_clk_nxt   = (state_nxt == ST_SHIFT_HI);
        sr_latch_nxt = (state_nxt == ST_LATCH);
        sr_data_nxt  = 1'b0;
        if ((state_nxt == ST_SHIFT_LO) || (state_nxt == ST_SHIFT_HI)) begin
            sr_data_nxt = MSB_FIRST ? shreg_nxt[DATA_W-1] : shreg_nxt[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_sent <= '0;
            capture   <= '0;
            shreg     <= '0;
            pending   <= 1'b1;
            bit_cnt   <= '0;
            sr_data   <= 1'b0;
            sr_clk    <= 1'b0;
            sr_latch  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            last_sent <= last_sent_nxt;
            capture   <= capture_nxt;
            shreg     <= shreg_nxt;
            pending   <= pending_nxt;
            bit_cnt   <= bit_cnt_nxt;
            sr_data   <= sr_data_nxt;
            sr_clk    <= sr_clk_nxt;
            sr_latch  <= sr_latch_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_ledr_shift_out.sv
// Scoreboard bench for ledr_shift_out: default instance plus a CLK_DIV=1, LSB-first instance.
module tb_ledr_shift_out;

    logic       clk = 1'b0;
    logic [1:0] rst;
    logic [7:0] pat0;
    logic [7:0] pat1;
    logic [1:0] sr_data;
    logic [1:0] sr_clk;
    logic [1:0] sr_latch;
    logic [1:0] busy;

    int checks = 0;
    int errors = 0;

    // Expected words in shift order: first bit shifted ends up in bit 7.
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    always #5 clk = ~clk;

    ledr_shift_out u_dut0 (
        .clk      (clk),
        .reset    (rst[0]),
        .pattern  (pat0),
        .sr_data  (sr_data[0]),
        .sr_clk   (sr_clk[0]),
        .sr_latch (sr_latch[0]),
        .busy     (busy[0])
    );

    ledr_shift_out #(
        .DATA_W    (8),
        .CLK_DIV   (1),
        .MSB_FIRST (1'b0)
    ) u_dut1 (
        .clk      (clk),
        .reset    (rst[1]),
        .pattern  (pat1),
        .sr_data  (sr_data[1]),
        .sr_clk   (sr_clk[1]),
        .sr_latch (sr_latch[1]),
        .busy     (busy[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Counts busy-high samples from the current one until busy drops, bounded by budget.
    task automatic wait_done(input int k, input int budget, output int hi);
        hi = 0;
        while (busy[k] && hi < budget) begin
            hi++;
            @(negedge clk);
        end
        if (busy[k]) begin
            errors++;
            $display("FAIL wait_done%0d: busy still high after %0d cycles", k, budget);
        end
    endtask

    // Monitor: reassembles each transfer and checks it against the scoreboard on latch fall.
    initial begin
        logic       sc_p[2];
        logic       sl_p[2];
        logic       sd_p[2];
        logic       bz_p[2];
        logic [7:0] word[2];
        int         nb[2];
        int         lw[2];
        int         tlen[2];
        logic [7:0] e;
        bit         have;
        for (int k = 0; k < 2; k++) begin
            sc_p[k] = 0; sl_p[k] = 0; sd_p[k] = 0; bz_p[k] = 0;
            word[k] = 0; nb[k] = 0; lw[k] = 0; tlen[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst[k]) begin
                    word[k] = 0; nb[k] = 0; lw[k] = 0; tlen[k] = 0;
                end else begin
                    if (sr_clk[k] || sr_latch[k]) begin
                        chk($sformatf("clk_latch_overlap%0d", k), int'(sr_clk[k] & sr_latch[k]), 0);
                    end
                    if (sr_clk[k] && sc_p[k]) begin
                        chk($sformatf("data_hold%0d", k), int'(sr_data[k]), int'(sd_p[k]));
                    end
                    if (sr_clk[k] && !sc_p[k]) begin
                        word[k] = {word[k][6:0], sr_data[k]};
                        nb[k]++;
                    end
                    if (sr_latch[k]) begin
                        lw[k]++;
                    end
                    if (sl_p[k] && !sr_latch[k]) begin
                        have = 0;
                        e    = 8'h00;
                        if (k == 0 && exp_q0.size() > 0) begin
                            have = 1; e = exp_q0.pop_front();
                        end else if (k == 1 && exp_q1.size() > 0) begin
                            have = 1; e = exp_q1.pop_front();
                        end
                        chk($sformatf("expected_transfer%0d", k), int'(have), 1);
                        chk($sformatf("shifted_word%0d", k), int'(word[k]), int'(e));
                        chk($sformatf("clk_rises%0d", k), nb[k], 8);
                        chk($sformatf("latch_width%0d", k), lw[k], (k == 0) ? 4 : 1);
                        chk($sformatf("transfer_len%0d", k), tlen[k], (k == 0) ? 69 : 18);
                        word[k] = 0; nb[k] = 0; lw[k] = 0;
                    end
                    if (busy[k] && (!bz_p[k] || (sl_p[k] && !sr_latch[k]))) begin
                        tlen[k] = 1;
                    end else if (busy[k]) begin
                        tlen[k]++;
                    end
                end
                sc_p[k] = sr_clk[k];
                sl_p[k] = sr_latch[k];
                sd_p[k] = sr_data[k];
                bz_p[k] = busy[k];
            end
        end
    end

    initial begin
        int hi;
        int act;
        int lat;
        logic lat_p;
        rst  = 2'b11;
        pat0 = 8'h00;
        pat1 = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({sr_data[0], sr_clk[0], sr_latch[0], busy[0]}), 0);

        // Post-reset refresh of an all-zero pattern.
        exp_q0.push_back(8'h00);
        rst[0] = 1'b0;
        @(negedge clk);
        chk("load_after_reset", int'(busy[0]), 1);
        wait_done(0, 200, hi);
        chk("busy_len_zero", hi, 69);
        chk("idle_after_zero", int'(busy[0]), 0);

        // A5 MSB-first: bits 1,0,1,0,0,1,0,1.
        pat0 = 8'hA5;
        exp_q0.push_back(8'hA5);
        @(negedge clk);
        chk("start_latency", int'(busy[0]), 1);
        wait_done(0, 200, hi);
        chk("busy_len_a5", hi, 69);

        // Steady pattern must produce no activity.
        act = 0;
        repeat (500) begin
            @(negedge clk);
            if (sr_clk[0] || sr_latch[0] || busy[0]) act++;
        end
        chk("hold_activity", act, 0);

        // Two mid-transfer changes coalesce into one back-to-back follow-up carrying F0.
        pat0 = 8'h0F;
        exp_q0.push_back(8'h0F);
        exp_q0.push_back(8'hF0);
        hi    = 0;
        lat   = 0;
        lat_p = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (c == 20) pat0 = 8'h33;
            if (c == 40) pat0 = 8'hF0;
            if (!busy[0]) break;
            hi++;
            if (sr_latch[0] && !lat_p) lat++;
            lat_p = sr_latch[0];
        end
        chk("coalesce_busy_len", hi, 138);
        chk("coalesce_latches", lat, 2);

        // Reset at cycle 30 of an FF transfer, then a full FF transfer.
        pat0 = 8'hFF;
        repeat (30) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        chk("reset_mid_outputs", int'({sr_data[0], sr_clk[0], sr_latch[0], busy[0]}), 0);
        rst[0] = 1'b0;
        exp_q0.push_back(8'hFF);
        @(negedge clk);
        chk("load_after_mid_reset", int'(busy[0]), 1);
        wait_done(0, 200, hi);
        chk("busy_len_ff", hi, 69);

        // CLK_DIV=1, LSB-first, pattern 01: first bit 1 then seven 0s.
        pat1 = 8'h01;
        exp_q1.push_back(8'h80);
        rst[1] = 1'b0;
        @(negedge clk);
        chk("load_after_reset_div1", int'(busy[1]), 1);
        wait_done(1, 100, hi);
        chk("busy_len_div1", hi, 18);

        repeat (5) @(negedge clk);
        chk("q0_drained", exp_q0.size(), 0);
        chk("q1_drained", exp_q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
